ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
- Parametrised single-port RAM read/write self-test engine.
- Owns an inferred single-port RAM and a sequencer: on `start`, writes a selectable data pattern to every address, reads every address back, and compares each word against the expected value.
- Reports done, pass/fail, an error count and the first failing address.
- Generalises the fixed 32x8 write/read exerciser to any width/depth, with pattern modes and result reporting; used as a board-level memory check.

Parameters:
- DW, 8, RAM data width in bits (1..64)
- AW, 5, RAM address width; depth DEPTH = 2**AW
- ECW, 16, error counter width

Ports:
- sys_clk  input  1  system clock; all logic on rising edge
- sys_rst  input  1  synchronous reset, active-high
- start  input  1  level/pulse; sampled only in IDLE
- pat_sel  input  2  pattern select, sampled with start
- seed  input  DW  pattern seed, sampled with start
- busy  output  1  high while a test runs
- done  output  1  one-cycle pulse at test end
- pass  output  1  result, valid from done until next accepted start
- err_cnt  output  ECW  mismatch count, saturating
- first_err_addr  output  AW  address of first mismatch; 0 if none

Behaviour:
- Reset (sys_rst=1 at an edge): state=IDLE; busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, internal addr=0. RAM contents are not cleared.
- Patterns exp(a), computed mod 2**DW:
  - 0: seed+a
  - 1: ~(seed+a)
  - 2: checkerboard; seed if a even, ~seed if a odd
  - 3: all ones
- pat_sel/seed are latched at start acceptance and held for the whole run.
- FSM: IDLE -> WRITE -> READ -> FLUSH -> DONE -> IDLE.
  - IDLE: start=1 at edge (cycle 0) -> WRITE; clear err_cnt, first_err_addr, pass; busy=1 from cycle 1.
  - WRITE: cycles 1..DEPTH; en=1, we=1, addr 0..DEPTH-1, din=exp(addr). At addr=DEPTH-1 -> READ with addr wrapping to 0.
  - READ: cycles DEPTH+1..2*DEPTH; en=1, we=0, addr 0..DEPTH-1. RAM read latency is 1 cycle. Compare pipeline: the address is delayed one cycle alongside the data. At addr=DEPTH-1 -> FLUSH.
  - FLUSH: cycle 2*DEPTH+1; compares the last read word; en=0.
  - DONE: cycle 2*DEPTH+2; done=1 for one cycle, busy=0, pass=(err_cnt==0 including the final compare) -> IDLE.
- Mismatch: err_cnt increments, saturating at all-ones. On the first mismatch of a run only, first_err_addr is set to the delayed address.
- start while busy is ignored, with no restart and no effect.
- Reset mid-run: returns to IDLE in the next cycle with all outputs at reset values; no done pulse.
- A start in the same cycle as DONE is not accepted. The next run needs start in IDLE.

Optional Feature:
- Macro: RAM_BIST_FAULT_INJECT_EN.
- Defined:
  - Adds ports `inj_en` (input, 1) and `inj_addr` (input, AW), sampled at start acceptance.
  - When latched inj_en=1, the WRITE-phase data at inj_addr is XORed with 1 (LSB flipped).
  - The compare still uses the unmodified exp(), so exactly one error is produced.
- Undefined: ports absent; write data is always exp(addr).

Decomposition:
- Package ram_bist_pkg holds:
  - state encoding (IDLE, WRITE, READ, FLUSH, DONE)
  - pattern codes PAT_INC, PAT_INV, PAT_CHK, PAT_ONES
  - function pat_data(pat, seed, addr)
- Sub-module sp_ram_infer:
  - parameters DW, AW; ports clk, en, we, addr, din, dout
  - registered read output, read-first on write
  - instantiated once inside ram_bist_ctrl

Test Plan:
- AW=5, DW=8, pat 0, seed 0, start at cycle 0 -> busy cycles 1..65, done pulse at cycle 66, pass=1, err_cnt=0, first_err_addr=0.
- Fault inject: inj_en=1, inj_addr=7, pat 2, seed 8'h55 -> err_cnt=1, first_err_addr=7, pass=0.
- start re-pulsed at cycle 10 of a run -> ignored; exactly one done, at cycle 66.
- sys_rst asserted at cycle 20 (WRITE) -> busy=0, err_cnt=0 next cycle, no done; a new start completes with pass=1.
- Back-to-back runs: pat 1, seed 8'hA5, then pat 3 started the cycle after returning to IDLE -> both pass=1; err_cnt/first_err_addr cleared at second start.
- Wrap: pat 0, seed 8'hF0 -> data wraps 8'hFF->8'h00 at addr 15; pass=1.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM self-test engine: sequencer states,
// pattern codes and the expected-data generator.
// Optional build feature: RAM_BIST_FAULT_INJECT_EN (see ram_bist_ctrl).
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_FLUSH,
        ST_DONE
    } bist_state_t;

    localparam logic [1:0] PAT_INC  = 2'd0;
    localparam logic [1:0] PAT_INV  = 2'd1;
    localparam logic [1:0] PAT_CHK  = 2'd2;
    localparam logic [1:0] PAT_ONES = 2'd3;

    // Computed at the widest supported data width; callers keep the low DW
    // bits, which makes the sum wrap modulo 2**DW.
    function automatic logic [63:0] pat_data(
        input logic [1:0]  pat,
        input logic [63:0] seed,
        input logic [63:0] addr
    );
        logic [63:0] sum;
        logic [63:0] res;
        sum = seed + addr;
        case (pat)
            PAT_INC: res = sum;
            PAT_INV: res = ~sum;
            PAT_CHK: res = addr[0] ? ~seed : seed;
            default: res = '1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sp_ram_infer.sv
// Inferred single-port RAM: one registered read port, read-first on write.
module sp_ram_infer #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_dout;

    // Enabled access: store on write, always return the old word
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= din;
            end
            r_dout <= r_mem[addr];
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM self-test engine: writes a pattern over the whole RAM, reads it back
// and reports pass/fail, a saturating error count and the first bad address.
// Optional build feature RAM_BIST_FAULT_INJECT_EN adds inj_en/inj_addr,
// which flip the LSB of one written word so a single mismatch is reported.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 5,
    parameter int unsigned ECW = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           start,
    input  logic [1:0]     pat_sel,
    input  logic [DW-1:0]  seed,
`ifdef RAM_BIST_FAULT_INJECT_EN
    input  logic           inj_en,
    input  logic [AW-1:0]  inj_addr,
`endif
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [ECW-1:0] err_cnt,
    output logic [AW-1:0]  first_err_addr
);

    bist_state_t    r_state;
    logic [AW-1:0]  r_addr;
    logic [AW-1:0]  r_addr_d;
    logic           r_cmp_vld;
    logic [1:0]     r_pat;
    logic [DW-1:0]  r_seed;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;
    logic [ECW-1:0] r_err_cnt;
    logic [AW-1:0]  r_first_err;
`ifdef RAM_BIST_FAULT_INJECT_EN
    logic           r_inj_en;
    logic [AW-1:0]  r_inj_addr;
`endif

    logic           w_ram_en;
    logic           w_ram_we;
    logic [DW-1:0]  w_exp_wr;
    logic [DW-1:0]  w_exp_rd;
    logic [DW-1:0]  w_wdata;
    logic [DW-1:0]  w_rdata;
    logic           w_mis;
    logic           w_last_addr;

    assign w_exp_wr    = DW'(pat_data(r_pat, 64'(r_seed), 64'(r_addr)));
    assign w_exp_rd    = DW'(pat_data(r_pat, 64'(r_seed), 64'(r_addr_d)));
    assign w_last_addr = (r_addr == '1);

    // RAM control and write data derived from the sequencer state
    always_comb begin
        w_ram_en = (r_state == ST_WRITE) || (r_state == ST_READ);
        w_ram_we = (r_state == ST_WRITE);
        w_wdata  = w_exp_wr;
`ifdef RAM_BIST_FAULT_INJECT_EN
        if (r_inj_en && (r_addr == r_inj_addr)) begin
            w_wdata = w_exp_wr ^ DW'(1);
        end
`endif
    end

    // Read data arrives one cycle after its address; compare against the
    // delayed address so the last word is checked in FLUSH.
    assign w_mis = r_cmp_vld && (w_rdata != w_exp_rd);

    sp_ram_infer #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk  (sys_clk),
        .en   (w_ram_en),
        .we   (w_ram_we),
        .addr (r_addr),
        .din  (w_wdata),
        .dout (w_rdata)
    );

    // Sequencer, compare bookkeeping and registered status outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_addr_d    <= '0;
            r_cmp_vld   <= 1'b0;
            r_pat       <= '0;
            r_seed      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
`ifdef RAM_BIST_FAULT_INJECT_EN
            r_inj_en    <= 1'b0;
            r_inj_addr  <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_cmp_vld <= 1'b0;

            if (w_mis) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (r_err_cnt == '0) begin
                    r_first_err <= r_addr_d;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_WRITE;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        r_addr      <= '0;
                        r_pat       <= pat_sel;
                        r_seed      <= seed;
`ifdef RAM_BIST_FAULT_INJECT_EN
                        r_inj_en    <= inj_en;
                        r_inj_addr  <= inj_addr;
`endif
                    end
                end
                ST_WRITE: begin
                    r_addr <= r_addr + 1'b1;
                    if (w_last_addr) begin
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_cmp_vld <= 1'b1;
                    r_addr_d  <= r_addr;
                    r_addr    <= r_addr + 1'b1;
                    if (w_last_addr) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err_cnt == '0) && !w_mis;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: directed and random runs checked against an
// array model of the RAM contents and the expected pattern words.
// Build with RAM_BIST_FAULT_INJECT_EN to also exercise fault injection.
module tb_ram_bist_ctrl;

    localparam int DW      = 8;
    localparam int AW      = 5;
    localparam int ECW     = 16;
    localparam int DEPTH   = 32;
    localparam int RUN_LAT = 2 * DEPTH + 2;

    logic           sys_clk = 1'b0;
    logic           sys_rst;
    logic           start;
    logic [1:0]     pat_sel;
    logic [DW-1:0]  seed;
`ifdef RAM_BIST_FAULT_INJECT_EN
    logic           inj_en;
    logic [AW-1:0]  inj_addr;
`endif
    logic           busy;
    logic           done;
    logic           pass;
    logic [ECW-1:0] err_cnt;
    logic [AW-1:0]  first_err_addr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] m_exp [DEPTH];
    logic [DW-1:0] m_mem [DEPTH];

    always #5 sys_clk = ~sys_clk;

    ram_bist_ctrl #(
        .DW  (DW),
        .AW  (AW),
        .ECW (ECW)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .start          (start),
        .pat_sel        (pat_sel),
        .seed           (seed),
`ifdef RAM_BIST_FAULT_INJECT_EN
        .inj_en         (inj_en),
        .inj_addr       (inj_addr),
`endif
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected word at address a, straight from the pattern rules
    function automatic logic [DW-1:0] ref_word(input logic [1:0] p, input logic [DW-1:0] s, input int a);
        logic [DW-1:0] av;
        av = DW'(a);
        case (p)
            2'd0:    return s + av;
            2'd1:    return ~(s + av);
            2'd2:    return (a % 2 == 1) ? ~s : s;
            default: return '1;
        endcase
    endfunction

    task automatic drive_start(input logic [1:0] p, input logic [DW-1:0] s, input logic ie, input logic [AW-1:0] ia);
        start   = 1'b1;
        pat_sel = p;
        seed    = s;
`ifdef RAM_BIST_FAULT_INJECT_EN
        inj_en   = ie;
        inj_addr = ia;
`else
        if (ie || (ia != '0)) $display("note: injection request ignored in this build");
`endif
    endtask

    task automatic scramble_inputs();
        start   = 1'b0;
        pat_sel = 2'($urandom);
        seed    = DW'($urandom);
`ifdef RAM_BIST_FAULT_INJECT_EN
        inj_en   = 1'($urandom);
        inj_addr = AW'($urandom);
`endif
    endtask

    // Overwrite RAM words behind the engine's back during READ
    task automatic corrupt(input int a);
        logic [DW-1:0] mask;
        logic [DW-1:0] v;
        mask = DW'($urandom);
        if (mask == '0) mask = DW'(1);
        v = m_exp[a] ^ mask;
        m_mem[a] = v;
        dut.u_ram.r_mem[a] = v;
    endtask

    // One full run; enters in any idle-or-DONE cycle, returns in the DONE cycle.
    // b2b: start is raised during the previous DONE cycle and must only be
    // taken one cycle later.
    task automatic do_run(input logic [1:0] p, input logic [DW-1:0] s, input logic ie,
                          input logic [AW-1:0] ia, input int ncor, input int repulse, input bit b2b);
        int  lat;
        int  nbusy;
        int  e_err;
        int  e_first;
        for (int a = 0; a < DEPTH; a++) begin
            m_exp[a] = ref_word(p, s, a);
            m_mem[a] = m_exp[a];
        end
        if (ie) m_mem[ia] = m_mem[ia] ^ DW'(1);

        if (b2b) drive_start(p, s, ie, ia);
        @(posedge sys_clk); #1;
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        if (!b2b) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                @(posedge sys_clk); #1;
            end
            drive_start(p, s, ie, ia);
        end
        @(posedge sys_clk); #1;
        scramble_inputs();
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_err_clr", 64'(err_cnt), 64'(0));
        chk("start_first_clr", 64'(first_err_addr), 64'(0));
        chk("start_pass_clr", 64'(pass), 64'(0));

        lat   = 0;
        nbusy = 0;
        for (int c = 1; c <= RUN_LAT + 40 && lat == 0; c++) begin
            if (busy) nbusy++;
            if (done) lat = c;
            if (c == repulse) begin
                start   = 1'b1;
                pat_sel = 2'($urandom);
                seed    = DW'($urandom);
            end
            if (c == repulse + 1) start = 1'b0;
            if (c == DEPTH + 1) begin
                for (int k = 0; k < ncor; k++) corrupt(int'($urandom_range(0, DEPTH - 1)));
            end
            if (lat == 0) begin
                @(posedge sys_clk); #1;
            end
        end
        start = 1'b0;

        e_err   = 0;
        e_first = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (m_mem[a] != m_exp[a]) begin
                if (e_err == 0) e_first = a;
                e_err++;
            end
        end
        chk("done_latency", 64'(lat), 64'(RUN_LAT));
        chk("busy_cycles", 64'(nbusy), 64'(RUN_LAT - 1));
        chk("pass", 64'(pass), 64'(e_err == 0));
        chk("err_cnt", 64'(err_cnt), 64'(e_err));
        chk("first_err_addr", 64'(first_err_addr), 64'(e_first));
    endtask

    // Start a run, reset it at cycle rc, confirm a clean abort
    task automatic reset_mid(input logic [1:0] p, input logic [DW-1:0] s, input int rc, input int ncor);
        int c;
        int ndone;
        for (int a = 0; a < DEPTH; a++) m_exp[a] = ref_word(p, s, a);
        @(posedge sys_clk); #1;
        drive_start(p, s, 1'b0, '0);
        @(posedge sys_clk); #1;
        scramble_inputs();
        c = 1;
        while (c < rc) begin
            @(posedge sys_clk); #1;
            c++;
            if (c == DEPTH + 1) begin
                for (int k = 0; k < ncor; k++) corrupt(k);
            end
        end
        chk("pre_rst_busy", 64'(busy), 64'(1));
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_pass", 64'(pass), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_first_err", 64'(first_err_addr), 64'(0));
        ndone = 0;
        for (int k = 0; k < RUN_LAT + 10; k++) begin
            @(posedge sys_clk); #1;
            if (done || busy) ndone++;
        end
        chk("rst_no_activity", 64'(ndone), 64'(0));
    endtask

    initial begin
        sys_rst = 1'b1;
        scramble_inputs();
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_pass", 64'(pass), 64'(0));
        chk("reset_err_cnt", 64'(err_cnt), 64'(0));
        chk("reset_first_err", 64'(first_err_addr), 64'(0));
        sys_rst = 1'b0;

        do_run(2'd0, 8'h00, 1'b0, '0, 0, 0, 1'b0);
        do_run(2'd0, 8'h00, 1'b0, '0, 0, 10, 1'b0);
        reset_mid(2'd0, 8'h3C, 20, 0);
        do_run(2'd2, 8'h5A, 1'b0, '0, 0, 0, 1'b0);
        reset_mid(2'd1, 8'h11, 50, 3);
        do_run(2'd0, 8'h77, 1'b0, '0, 4, 0, 1'b0);
        do_run(2'd1, 8'hA5, 1'b0, '0, 0, 0, 1'b1);
        do_run(2'd3, 8'h00, 1'b0, '0, 0, 0, 1'b1);
        do_run(2'd0, 8'hF0, 1'b0, '0, 0, 0, 1'b0);
`ifdef RAM_BIST_FAULT_INJECT_EN
        do_run(2'd2, 8'h55, 1'b1, 5'd7, 0, 0, 1'b0);
        do_run(2'd1, 8'h3E, 1'b1, 5'd31, 0, 0, 1'b1);
`endif
        for (int r = 0; r < 8; r++) begin
            do_run(2'($urandom), DW'($urandom), 1'b0, '0,
                   int'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 60)) : 0,
                   1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
